// File: rtl/keypad_scan_if.sv
// ============================================================================
// Module   : keypad_scan_if
// Purpose  : Keypad matrix pins and accepted-key report for keypad_scan.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface keypad_scan_if;
    logic [3:0] o_col_enb;
    logic [3:0] i_row;
    logic [3:0] o_key_num;
    logic       o_key_valid;
    logic       o_key_held;

    // master: the scanner; slave: the keypad/consumer side
    modport master (
        output o_col_enb,
        output o_key_num,
        output o_key_valid,
        output o_key_held,
        input  i_row
    );

    modport slave (
        input  o_col_enb,
        input  o_key_num,
        input  o_key_valid,
        input  o_key_held,
        output i_row
    );
endinterface

`default_nettype wire

// File: rtl/keypad_scan.sv
// ============================================================================
// Module   : keypad_scan
// Purpose  : 4x4 active-low matrix keypad scanner with frame debounce.
//            Optional auto-repeat when KEYPAD_SCAN_REPEAT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_scan #(
    parameter int SCAN_DIV      = 5000,
    parameter int DEBOUNCE_CNT  = 4,
    parameter int REPEAT_FRAMES = 64
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    keypad_scan_if.master   kp
);

    localparam int                 c_STEP_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(SCAN_DIV - 1);
    localparam logic [3:0]         c_DEB_LAST  = 4'(DEBOUNCE_CNT);

    generate
        if (SCAN_DIV < 2 || DEBOUNCE_CNT < 2 || DEBOUNCE_CNT > 15 ||
            REPEAT_FRAMES < 1 || REPEAT_FRAMES > 255) begin : g_param_check
            $error("keypad_scan: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    logic [3:0]          r_row_meta;
    logic [3:0]          r_row_sync;
    logic [c_STEP_W-1:0] r_step;
    logic [1:0]          r_col;
    logic [3:0]          r_col_enb;
    logic [1:0]          r_acc_cnt;
    logic [3:0]          r_acc_code;

    logic                w_tick;
    logic [1:0]          w_col_nxt;
    logic [3:0]          w_pressed;
    logic [2:0]          w_col_cnt;
    logic [2:0]          w_sum;
    logic [1:0]          w_cnt_sat;
    logic [1:0]          w_row_idx;
    logic [3:0]          w_code;
    logic                w_frame_done;
    logic                w_res_none;
    logic                w_res_key;

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cand, w_cand_nxt;
    logic [3:0]          r_stab, w_stab_nxt;
    logic [3:0]          w_stab_inc;
    logic [3:0]          r_key_num, w_key_num_nxt;
    logic                r_key_valid, w_key_valid_nxt;
    logic                r_key_held, w_key_held_nxt;
`ifdef KEYPAD_SCAN_REPEAT_EN
    logic [7:0]          r_rep_cnt, w_rep_nxt;
    logic [7:0]          w_rep_inc;
`endif

    // ------------------------------------------------------------------
    // Scan timing and frame accumulation
    // ------------------------------------------------------------------
    assign w_tick    = (r_step == c_STEP_LAST);
    assign w_col_nxt = r_col + 2'd1;
    assign w_pressed = ~r_row_sync;
    assign w_col_cnt = {2'b00, w_pressed[0]} + {2'b00, w_pressed[1]} +
                       {2'b00, w_pressed[2]} + {2'b00, w_pressed[3]};
    assign w_sum     = {1'b0, r_acc_cnt} + w_col_cnt;
    // Only 0 / 1 / "2 or more" matter, so the count saturates at 2
    assign w_cnt_sat = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];

    always_comb begin
        w_row_idx = 2'd0;
        if (w_pressed[0])      w_row_idx = 2'd0;
        else if (w_pressed[1]) w_row_idx = 2'd1;
        else if (w_pressed[2]) w_row_idx = 2'd2;
        else if (w_pressed[3]) w_row_idx = 2'd3;
    end

    // First hit wins: earlier columns were accumulated before this one
    assign w_code       = (r_acc_cnt != 2'd0) ? r_acc_code : {w_row_idx, r_col};
    assign w_frame_done = w_tick && (r_col == 2'd3);
    assign w_res_none   = (w_cnt_sat == 2'd0);
    assign w_res_key    = (w_cnt_sat == 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
            r_step     <= '0;
            r_col      <= 2'd0;
            r_col_enb  <= 4'b1110;
            r_acc_cnt  <= 2'd0;
            r_acc_code <= 4'd0;
        end else begin
            r_row_meta <= kp.i_row;
            r_row_sync <= r_row_meta;
            if (w_tick) begin
                r_step    <= '0;
                r_col     <= w_col_nxt;
                r_col_enb <= ~(4'b0001 << w_col_nxt);
                if (r_col == 2'd3) begin
                    r_acc_cnt  <= 2'd0;
                    r_acc_code <= 4'd0;
                end else begin
                    r_acc_cnt  <= w_cnt_sat;
                    r_acc_code <= w_code;
                end
            end else begin
                r_step <= r_step + c_STEP_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM, advanced once per frame result
    // ------------------------------------------------------------------
    assign w_stab_inc = r_stab + 4'd1;
`ifdef KEYPAD_SCAN_REPEAT_EN
    assign w_rep_inc  = r_rep_cnt + 8'd1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cand      <= 4'd0;
            r_stab      <= 4'd0;
            r_key_num   <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
            r_rep_cnt   <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_stab      <= w_stab_nxt;
            r_key_num   <= w_key_num_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_held  <= w_key_held_nxt;
`ifdef KEYPAD_SCAN_REPEAT_EN
            r_rep_cnt   <= w_rep_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cand_nxt      = r_cand;
        w_stab_nxt      = r_stab;
        w_key_num_nxt   = r_key_num;
        w_key_valid_nxt = 1'b0;
        w_key_held_nxt  = r_key_held;
`ifdef KEYPAD_SCAN_REPEAT_EN
        w_rep_nxt       = r_rep_cnt;
`endif
        if (w_frame_done) begin
            case (r_state)
                S_IDLE: begin
                    if (w_res_key) begin
                        w_cand_nxt  = w_code;
                        w_stab_nxt  = 4'd1;
                        w_state_nxt = S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (w_res_key && (w_code == r_cand)) begin
                        w_stab_nxt = w_stab_inc;
                        if (w_stab_inc == c_DEB_LAST) begin
                            w_state_nxt     = S_PRESSED;
                            w_key_num_nxt   = r_cand;
                            w_key_valid_nxt = 1'b1;
                            w_key_held_nxt  = 1'b1;
`ifdef KEYPAD_SCAN_REPEAT_EN
                            w_rep_nxt       = 8'd0;
`endif
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_PRESSED: begin
                    if (w_res_none) begin
                        w_stab_nxt  = 4'd1;
                        w_state_nxt = S_RELEASE;
`ifdef KEYPAD_SCAN_REPEAT_EN
                        w_rep_nxt   = 8'd0;
                    end else if (w_rep_inc == 8'(REPEAT_FRAMES)) begin
                        w_key_valid_nxt = 1'b1;
                        w_rep_nxt       = 8'd0;
                    end else begin
                        w_rep_nxt = w_rep_inc;
`endif
                    end
                end
                S_RELEASE: begin
                    if (w_res_none) begin
                        w_stab_nxt = w_stab_inc;
                        if (w_stab_inc == c_DEB_LAST) begin
                            w_state_nxt    = S_IDLE;
                            w_key_held_nxt = 1'b0;
                        end
                    end else begin
                        w_state_nxt = S_PRESSED;
`ifdef KEYPAD_SCAN_REPEAT_EN
                        w_rep_nxt   = 8'd0;
`endif
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign kp.o_col_enb   = r_col_enb;
    assign kp.o_key_num   = r_key_num;
    assign kp.o_key_valid = r_key_valid;
    assign kp.o_key_held  = r_key_held;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
// ============================================================================
// Module   : tb_keypad_scan
// Purpose  : Directed self-checking bench for keypad_scan with a keypad model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keypad_scan;

`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam int c_REP = 1;
`else
    localparam int c_REP = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] keys;
    logic [3:0]  row_v;
    int          n_vec;
    int          n_miss;

    keypad_scan_if bus ();

    keypad_scan #(
        .SCAN_DIV      (4),
        .DEBOUNCE_CNT  (3),
        .REPEAT_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key r*4+c shorts row r to column c
    always_comb begin
        row_v = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !bus.o_col_enb[c]) row_v[r] = 1'b0;
    end
    assign bus.i_row = row_v;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one frame of key state starting at a frame boundary, then check
    task automatic run_frame(input string tag, input logic [15:0] k, input int exp_v,
                             input logic [3:0] exp_num, input logic exp_held);
        int nv;
        int at;
        nv   = 0;
        at   = 0;
        keys = k;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (bus.o_key_valid) begin
                nv++;
                at = i;
            end
        end
        chk({tag, "_nvalid"}, nv, exp_v);
        chk({tag, "_at"}, at, (exp_v != 0) ? 16 : 0);
        chk({tag, "_num"}, bus.o_key_num, exp_num);
        chk({tag, "_held"}, bus.o_key_held, exp_held);
    endtask

    logic [3:0] exp_enb [4];

    initial begin
        exp_enb = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        n_vec   = 0;
        n_miss  = 0;
        rst_n   = 1'b0;
        keys    = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_col_enb", bus.o_col_enb, 4'b1110);
        chk("rst_num", bus.o_key_num, 0);
        chk("rst_valid", bus.o_key_valid, 0);
        chk("rst_held", bus.o_key_held, 0);

        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if ((i % 4) == 2)
                chk($sformatf("col_enb_%0d", i), bus.o_col_enb, exp_enb[(i / 4) % 4]);
        end
        chk("idle_valid", bus.o_key_valid, 0);

        // Clean press of key 6 (row1, col2)
        run_frame("p6_f1", 16'h0040, 0, 4'd0, 1'b0);
        run_frame("p6_f2", 16'h0040, 0, 4'd0, 1'b0);
        run_frame("p6_f3", 16'h0040, 1, 4'd6, 1'b1);
        run_frame("p6_f4", 16'h0040, 0, 4'd6, 1'b1);
        run_frame("p6_f5", 16'h0040, c_REP, 4'd6, 1'b1);

        // Short release then re-press, then full release
        run_frame("r6_n1", 16'h0000, 0, 4'd6, 1'b1);
        run_frame("r6_n2", 16'h0000, 0, 4'd6, 1'b1);
        run_frame("r6_back", 16'h0040, 0, 4'd6, 1'b1);
        run_frame("r6_m1", 16'h0000, 0, 4'd6, 1'b1);
        run_frame("r6_m2", 16'h0000, 0, 4'd6, 1'b1);
        run_frame("r6_m3", 16'h0000, 0, 4'd6, 1'b0);

        // Bounce: a single NONE frame restarts debounce
        run_frame("b_f1", 16'h0040, 0, 4'd6, 1'b0);
        run_frame("b_f2", 16'h0040, 0, 4'd6, 1'b0);
        run_frame("b_gap", 16'h0000, 0, 4'd6, 1'b0);
        run_frame("b_f3", 16'h0040, 0, 4'd6, 1'b0);
        run_frame("b_f4", 16'h0040, 0, 4'd6, 1'b0);
        run_frame("b_f5", 16'h0040, 1, 4'd6, 1'b1);
        run_frame("b_r1", 16'h0000, 0, 4'd6, 1'b1);
        run_frame("b_r2", 16'h0000, 0, 4'd6, 1'b1);
        run_frame("b_r3", 16'h0000, 0, 4'd6, 1'b0);

        // Keys 0 and 15 together never qualify
        for (int f = 0; f < 6; f++)
            run_frame($sformatf("multi_%0d", f), 16'h8001, 0, 4'd6, 1'b0);
        run_frame("multi_end", 16'h0000, 0, 4'd6, 1'b0);

        // Corner codes, and a different key while pressed is ignored
        run_frame("k15_f1", 16'h8000, 0, 4'd6, 1'b0);
        run_frame("k15_f2", 16'h8000, 0, 4'd6, 1'b0);
        run_frame("k15_f3", 16'h8000, 1, 4'd15, 1'b1);
        run_frame("k15_k3", 16'h0008, 0, 4'd15, 1'b1);
        run_frame("k15_r1", 16'h0000, 0, 4'd15, 1'b1);
        run_frame("k15_r2", 16'h0000, 0, 4'd15, 1'b1);
        run_frame("k15_r3", 16'h0000, 0, 4'd15, 1'b0);
        run_frame("k0_f1", 16'h0001, 0, 4'd15, 1'b0);
        run_frame("k0_f2", 16'h0001, 0, 4'd15, 1'b0);
        run_frame("k0_f3", 16'h0001, 1, 4'd0, 1'b1);
        run_frame("k0_r1", 16'h0000, 0, 4'd0, 1'b1);
        run_frame("k0_r2", 16'h0000, 0, 4'd0, 1'b1);
        run_frame("k0_r3", 16'h0000, 0, 4'd0, 1'b0);

        // Long hold of key 9 (row2, col1)
        run_frame("k9_f1", 16'h0200, 0, 4'd0, 1'b0);
        run_frame("k9_f2", 16'h0200, 0, 4'd0, 1'b0);
        run_frame("k9_f3", 16'h0200, 1, 4'd9, 1'b1);
        run_frame("k9_f4", 16'h0200, 0, 4'd9, 1'b1);
        run_frame("k9_f5", 16'h0200, c_REP, 4'd9, 1'b1);
        run_frame("k9_f6", 16'h0200, 0, 4'd9, 1'b1);
        run_frame("k9_f7", 16'h0200, c_REP, 4'd9, 1'b1);

        // Reset mid-frame with key still held: debounce from scratch
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_col_enb", bus.o_col_enb, 4'b1110);
        chk("mid_rst_num", bus.o_key_num, 0);
        chk("mid_rst_valid", bus.o_key_valid, 0);
        chk("mid_rst_held", bus.o_key_held, 0);
        rst_n = 1'b1;
        run_frame("rk9_f1", 16'h0200, 0, 4'd0, 1'b0);
        run_frame("rk9_f2", 16'h0200, 0, 4'd0, 1'b0);
        run_frame("rk9_f3", 16'h0200, 1, 4'd9, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
